// File: rtl/fifo_write_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states
//   STAT_W      : width of every statistics counter
//   idx_width() : index width for a requester count (minimum 1 bit)
package fifo_write_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        : request vector, one bit per requester
//   last_grant : index of the most recently released owner
//   winner     : first requesting index after last_grant, with wrap-around
//   any        : at least one request is present (winner is valid)
module fifo_write_arb_rr_pick
    import fifo_write_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    int idx;

    // Walk from the farthest candidate (last_grant itself) to the nearest
    // (last_grant+1); the nearest requester is written last and wins.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[IDX_W'(idx)]) winner = IDX_W'(idx);
        end
        any = |req;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port between NUM_REQ
// valid/ready requesters in the write clock domain. One owner at a time is
// granted for up to BURST_MAX beats; writes are never issued while
// write_full is high.
// Ports:
//   write_clk, write_reset_n : clock, synchronous active-low reset
//   req_valid/req_data/req_last/req_ready : per-requester beat streams,
//                              requester i data at [i*DSIZE +: DSIZE]
//   write_full    : FIFO full flag
//   write_enable, write_data : FIFO write port (combinational from owner)
//   grant_id      : current owner, valid while busy
//   busy          : high while a grant is held
// Optional build macro FIFO_WRITE_ARB_STATS_EN adds:
//   beat_count    : per-requester accepted-beat counters, STAT_W each
//   stall_count   : cycles the owner had data but the FIFO was full
//   Counters saturate at all-ones; arbitration is unaffected.
module fifo_write_arbiter
    import fifo_write_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DSIZE     = 32,
    parameter int BURST_MAX = 4,
    localparam int IDX_W    = idx_width(NUM_REQ)
) (
    input  logic                     write_clk,
    input  logic                     write_reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DSIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     write_full,
    output logic                     write_enable,
    output logic [DSIZE-1:0]         write_data,
    output logic [IDX_W-1:0]         grant_id,
`ifdef FIFO_WRITE_ARB_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0] beat_count,
    output logic [STAT_W-1:0]         stall_count,
`endif
    output logic                     busy
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    arb_state_t               state, state_nxt;
    logic [IDX_W-1:0]         owner, owner_nxt;
    logic [IDX_W-1:0]         last_grant, last_grant_nxt;
    logic [CNT_W-1:0]         beat_cnt, beat_cnt_nxt;
    logic [IDX_W-1:0]         pick;
    logic                     pick_any;
    logic [NUM_REQ-1:0][DSIZE-1:0] data_vec;
    logic                     owner_vld, owner_last, accept, at_limit;

    assign data_vec   = req_data;
    assign busy       = (state == ARB_GRANT);
    assign grant_id   = owner;
    assign owner_vld  = req_valid[owner];
    assign owner_last = req_last[owner];
    assign accept     = busy && owner_vld && !write_full;
    assign at_limit   = (beat_cnt == CNT_W'(BURST_MAX - 1));

    fifo_write_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (pick),
        .any        (pick_any)
    );

    // Write port is combinational from the registered owner so that a full
    // FIFO blocks the write in the very same cycle.
    always_comb begin
        req_ready    = '0;
        write_enable = accept;
        write_data   = '0;
        if (busy) begin
            req_ready[owner] = !write_full;
            write_data       = data_vec[owner];
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    owner_nxt    = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Owner without data releases immediately, even while full;
                // a full FIFO otherwise holds the grant and the count.
                if (!owner_vld) begin
                    state_nxt      = ARB_IDLE;
                    last_grant_nxt = owner;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (owner_last || at_limit) begin
                        state_nxt      = ARB_IDLE;
                        last_grant_nxt = owner;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] beat_cnt_r;
    logic                           stall_cyc;

    assign beat_count = beat_cnt_r;
    assign stall_cyc  = busy && owner_vld && write_full;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat_stat
        always_ff @(posedge write_clk) begin
            if (!write_reset_n) begin
                beat_cnt_r[g] <= '0;
            end else if (accept && owner == IDX_W'(g) && beat_cnt_r[g] != '1) begin
                beat_cnt_r[g] <= beat_cnt_r[g] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
            stall_count <= '0;
        end else if (stall_cyc && stall_count != '1) begin
            stall_count <= stall_count + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (NUM_REQ=4, DSIZE=32,
// BURST_MAX=4). Requester models hold per-requester beat queues; the FIFO
// side pops an expected-word queue on every write_enable.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DSIZE     = 32;
    localparam int BURST_MAX = 4;
    localparam int IDX_W     = 2;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic             last;
    } beat_t;

    logic                          clk = 1'b0;
    logic                          write_reset_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][DSIZE-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          write_full;
    logic                          write_enable;
    logic [DSIZE-1:0]              write_data;
    logic [IDX_W-1:0]              grant_id;
    logic                          busy;
`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0]      beat_count;
    logic [15:0]                   stall_count;
`endif

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DSIZE     (DSIZE),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .write_clk     (clk),
        .write_reset_n (write_reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .write_full    (write_full),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .grant_id      (grant_id),
`ifdef FIFO_WRITE_ARB_STATS_EN
        .beat_count    (beat_count),
        .stall_count   (stall_count),
`endif
        .busy          (busy)
    );

    beat_t            src_q [NUM_REQ][$];
    logic [DSIZE-1:0] exp_q [$];
    logic [NUM_REQ-1:0] drop;
    int gnt_q [$];
    int run_q [$];
    int gap_q [$];
    int wr_cnt = 0, cyc = 0, run_len = 0, idle_len = 0, rise_cyc = 0, vld_cyc = 0;
    logic prev_busy = 1'b0, prev_any = 1'b0;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_beat(input int r, input logic [DSIZE-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[r].push_back(b);
    endtask

    // Requester drive at negedge, FIFO-side monitor just before posedge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            logic [NUM_REQ-1:0] own_mask;
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (src_q[i].size() != 0) && !drop[i];
                req_data[i]  = (src_q[i].size() != 0) ? src_q[i][0].data : '0;
                req_last[i]  = (src_q[i].size() != 0) ? src_q[i][0].last : 1'b0;
            end
            #4;
            cyc++;
            if (write_full) chk("no_write_when_full", write_enable, 0);
            own_mask = busy ? (NUM_REQ'(1) << grant_id) : '0;
            chk("ready_owner_only", req_ready & ~own_mask, 0);
            if (write_enable) begin
                wr_cnt++;
                if (exp_q.size() == 0) chk("unexpected_write", write_data, 0 - 1);
                else chk("wdata", write_data, exp_q.pop_front());
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
            if (busy) begin
                if (!prev_busy) begin
                    gnt_q.push_back(int'(grant_id));
                    gap_q.push_back(idle_len);
                    rise_cyc = cyc;
                    run_len  = 0;
                end
                run_len++;
            end else begin
                if (prev_busy) begin
                    run_q.push_back(run_len);
                    idle_len = 0;
                end
                idle_len++;
            end
            if ((|req_valid) && !prev_any) vld_cyc = cyc;
            prev_busy = busy;
            prev_any  = |req_valid;
        end
    end

    task automatic clear_logs();
        gnt_q.delete();
        run_q.delete();
        gap_q.delete();
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while ((any_pending() || busy || exp_q.size() != 0) && t < budget) begin
            @(posedge clk); #1; t++;
        end
        if (t >= budget) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic wait_wr(input int target, input int budget);
        int t = 0;
        while (wr_cnt < target && t < budget) begin @(posedge clk); #1; t++; end
        if (wr_cnt < target) chk("wr_timeout", wr_cnt, target);
    endtask

    task automatic wait_grant(input int id, input int budget);
        int t = 0;
        while (!(busy && int'(grant_id) == id) && t < budget) begin @(posedge clk); #1; t++; end
        if (t >= budget) chk("grant_timeout", grant_id, id);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_write_enable"}, write_enable, 0);
        chk({tag, "_write_data"}, write_data, 0);
    endtask

    task automatic do_reset();
        write_reset_n = 1'b0;
        @(posedge clk); #1;
        write_reset_n = 1'b1;
    endtask

    initial begin
        int base;
        write_reset_n = 1'b0;
        write_full    = 1'b0;
        drop          = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef FIFO_WRITE_ARB_STATS_EN
        chk("reset_stall_count", stall_count, 0);
        chk("reset_beat_count", beat_count, 0);
`endif
        write_reset_n = 1'b1;
        @(posedge clk); #1;

        // Single requester 2, 3-beat packet.
        clear_logs();
        base = wr_cnt;
        push_beat(2, 32'hA1, 1'b0); exp_q.push_back(32'hA1);
        push_beat(2, 32'hA2, 1'b0); exp_q.push_back(32'hA2);
        push_beat(2, 32'hA3, 1'b1); exp_q.push_back(32'hA3);
        wait_done(50);
        chk("single_writes", wr_cnt - base, 3);
        chk("single_grants", gnt_q.size(), 1);
        if (gnt_q.size() > 0) chk("single_grant_id", gnt_q[0], 2);
        if (run_q.size() > 0) chk("single_busy_len", run_q[0], 3);
        chk("single_busy_latency", rise_cyc - vld_cyc, 1);

        // Round-robin with continuous load: 8 bursts of 4.
        do_reset();
        clear_logs();
        base = wr_cnt;
        for (int r = 0; r < NUM_REQ; r++)
            for (int b = 0; b < 8; b++)
                push_beat(r, {16'hB000, 8'(r), 8'(b)}, 1'b0);
        for (int rnd = 0; rnd < 2; rnd++)
            for (int r = 0; r < NUM_REQ; r++)
                for (int b = 0; b < BURST_MAX; b++)
                    exp_q.push_back({16'hB000, 8'(r), 8'(rnd * BURST_MAX + b)});
        wait_done(200);
        chk("rr_writes", wr_cnt - base, 32);
        chk("rr_grants", gnt_q.size(), 8);
        for (int k = 0; k < gnt_q.size() && k < 8; k++) chk("rr_grant_order", gnt_q[k], k % NUM_REQ);
        for (int k = 0; k < run_q.size() && k < 8; k++) chk("rr_burst_len", run_q[k], BURST_MAX);
        for (int k = 1; k < gap_q.size() && k < 8; k++) chk("rr_idle_gap", gap_q[k], 1);
`ifdef FIFO_WRITE_ARB_STATS_EN
        for (int r = 0; r < NUM_REQ; r++) chk("stat_beat_count", beat_count[r], 8);
`endif

        // Full stall of 10 cycles during requester 1's grant.
        clear_logs();
        base = wr_cnt;
        for (int b = 0; b < 4; b++) begin
            push_beat(1, 32'hC0 + b, b == 3);
            exp_q.push_back(32'hC0 + b);
        end
        wait_wr(base + 1, 20);
        write_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #2;
            chk("full_busy_held", busy, 1);
            chk("full_grant_held", grant_id, 1);
            chk("full_no_write", write_enable, 0);
            chk("full_no_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        write_full = 1'b0;
        wait_done(50);
        chk("full_writes", wr_cnt - base, 4);
        chk("full_grants", gnt_q.size(), 1);
        if (run_q.size() > 0) chk("full_busy_len", run_q[0], 14);
`ifdef FIFO_WRITE_ARB_STATS_EN
        chk("stat_stall_count", stall_count, 10);
`endif

        // Early release: owner 2 drops valid after one beat.
        clear_logs();
        push_beat(2, 32'hD0, 1'b0);
        push_beat(2, 32'hD1, 1'b0);
        push_beat(2, 32'hD2, 1'b1);
        push_beat(3, 32'hE0, 1'b0);
        push_beat(3, 32'hE1, 1'b1);
        exp_q.push_back(32'hD0); exp_q.push_back(32'hE0); exp_q.push_back(32'hE1);
        exp_q.push_back(32'hD1); exp_q.push_back(32'hD2);
        base = wr_cnt;
        wait_wr(base + 1, 20);
        drop[2] = 1'b1;
        wait_grant(3, 20);
        drop[2] = 1'b0;
        wait_done(50);
        chk("early_grants", gnt_q.size(), 3);
        if (gnt_q.size() == 3) begin
            chk("early_grant0", gnt_q[0], 2);
            chk("early_grant1", gnt_q[1], 3);
            chk("early_grant2", gnt_q[2], 2);
        end
        if (run_q.size() > 0) chk("early_release_len", run_q[0], 2);
        if (gap_q.size() > 1) chk("early_idle_gap", gap_q[1], 1);

        // Reset during beat 2 of requester 1's burst.
        clear_logs();
        for (int b = 0; b < 4; b++) push_beat(1, 32'hF0 + b, b == 3);
        exp_q.push_back(32'hF0); exp_q.push_back(32'hF1); exp_q.push_back(32'h60);
        exp_q.push_back(32'hF2); exp_q.push_back(32'hF3); exp_q.push_back(32'h70);
        base = wr_cnt;
        wait_wr(base + 1, 20);
        write_reset_n = 1'b0;
        push_beat(0, 32'h60, 1'b1);
        push_beat(3, 32'h70, 1'b1);
        @(posedge clk); #1;
        check_idle_outputs("midreset");
`ifdef FIFO_WRITE_ARB_STATS_EN
        chk("midreset_stall_count", stall_count, 0);
`endif
        write_reset_n = 1'b1;
        wait_done(80);
        chk("rst_grants", gnt_q.size(), 4);
        if (gnt_q.size() == 4) begin
            chk("rst_first_winner", gnt_q[1], 0);
            chk("rst_second_winner", gnt_q[2], 1);
            chk("rst_third_winner", gnt_q[3], 3);
        end
        chk("rst_writes", wr_cnt - base, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
